// File: rtl/mult_sequencer.sv
// mult_sequencer
//   Two-requester, single-engine shift-add multiplier. A round-robin arbiter
//   accepts one operand pair at a time. The pair is multiplied over WIDTH
//   shift-add steps, and the product is held until the consumer takes it.
//
//   State table
//     state | meaning
//     IDLE  | waiting for a request; ready is driven to the granted requester
//     RUN   | WIDTH shift-add steps, then one edge latching the product
//     DONE  | result presented; held until res_ready
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/a/b       requester N operand handshake (N = 0, 1)
//   res_valid/ready            result handshake
//   res_id                     owner of the presented result
//   res_lo/res_hi              product low/high halves
//   busy                       state is not IDLE
module mult_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               res_id_q, res_id_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               grant1;

  // Requester 1 wins when it is alone or when both ask and the pointer names it.
  assign grant1 = req1_valid && (!req0_valid || ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_id_q <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_id_q <= res_id_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_id_d   = res_id_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = req0_valid && !grant1;
        req1_ready = grant1;
        if (req0_valid || req1_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, (grant1 ? req1_a : req0_a)};
          mplier_d = grant1 ? req1_b : req0_b;
          acc_d    = '0;
          cnt_d    = '0;
          owner_d  = grant1;
          ptr_d    = !grant1;
          state_d  = RUN;
        end
      end

      RUN: begin
        // After WIDTH steps the counter reaches WIDTH. That final RUN edge
        // copies the finished product into the result registers.
        if (cnt_q == CW'(WIDTH)) begin
          res_lo_d = acc_q[WIDTH-1:0];
          res_hi_d = acc_q[2*WIDTH-1:WIDTH];
          res_id_d = owner_q;
          state_d  = DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_id    = res_id_q;
  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;

endmodule
